// File: rtl/mem_resp_queue.sv
// In-order MEM-stage queue: tracks outstanding SRAM loads, aligns load data, retires to WB in order.
// Optional build macro: MEM_RESP_CUT_THROUGH_EN (0-cycle data_ok -> WB path for a waiting head load).
module mem_resp_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned META_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic [4:0]        in_ld_ctrl,
  input  logic [1:0]        in_addr_lo,
  input  logic [31:0]       in_result,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [META_W-1:0] in_meta,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_rf_we,
  output logic [4:0]        out_rf_waddr,
  output logic [META_W-1:0] out_meta,
  output logic              byp_valid,
  output logic [4:0]        byp_waddr,
  output logic              byp_data_rdy,
  output logic [31:0]       byp_data
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // ld_ctrl bit order: {ld_w, ld_b, ld_bu, ld_h, ld_hu}
  function automatic logic [31:0] extract(input logic [31:0] w, input logic is_load,
                                          input logic [4:0] ctrl, input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    r = w;
    if (is_load) begin
      if (ctrl[3])      r = {{24{b[7]}}, b};
      else if (ctrl[2]) r = {24'b0, b};
      else if (ctrl[1]) r = {{16{h[15]}}, h};
      else if (ctrl[0]) r = {16'b0, h};
    end
    return r;
  endfunction

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, resp_ptr;
  logic [CW-1:0]     count_q, discard_q, count_d, discard_flush, n_wait;
  logic              has_wait, push, pop, stored_valid, cut;
  logic [PW-1:0]     idx;

  logic              busy_q    [DEPTH];
  logic              is_load_q [DEPTH];
  logic              got_q     [DEPTH];
  logic [4:0]        ld_ctrl_q [DEPTH];
  logic [1:0]        addr_lo_q [DEPTH];
  logic [31:0]       word_q    [DEPTH];
  logic              rf_we_q   [DEPTH];
  logic [4:0]        waddr_q   [DEPTH];
  logic [META_W-1:0] meta_q    [DEPTH];

  // Responses arrive in order, so they belong to the oldest waiting load.
  always_comb begin
    resp_ptr = rd_ptr_q;
    has_wait = 1'b0;
    n_wait   = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (busy_q[idx] && is_load_q[idx] && !got_q[idx] && !has_wait) begin
        resp_ptr = idx;
        has_wait = 1'b1;
      end
      if (busy_q[i] && is_load_q[i] && !got_q[i]) n_wait = n_wait + CW'(1);
    end
  end

  always_comb begin
    discard_flush = discard_q + n_wait;
    if (data_ok && discard_flush != '0) discard_flush = discard_flush - CW'(1);
  end

  assign in_ready     = ({1'b0, count_q} + {1'b0, discard_q}) < (CW + 1)'(DEPTH);
  assign stored_valid = busy_q[rd_ptr_q] & got_q[rd_ptr_q];

`ifdef MEM_RESP_CUT_THROUGH_EN
  assign cut = busy_q[rd_ptr_q] & is_load_q[rd_ptr_q] & ~got_q[rd_ptr_q] & (discard_q == '0)
             & has_wait & (resp_ptr == rd_ptr_q) & data_ok;
  assign out_result = cut ? extract(rdata, 1'b1, ld_ctrl_q[rd_ptr_q], addr_lo_q[rd_ptr_q])
                          : extract(word_q[rd_ptr_q], is_load_q[rd_ptr_q], ld_ctrl_q[rd_ptr_q],
                                    addr_lo_q[rd_ptr_q]);
`else
  assign cut = 1'b0;
  assign out_result = extract(word_q[rd_ptr_q], is_load_q[rd_ptr_q], ld_ctrl_q[rd_ptr_q],
                              addr_lo_q[rd_ptr_q]);
`endif

  assign out_valid    = stored_valid | cut;
  assign out_rf_we    = rf_we_q[rd_ptr_q];
  assign out_rf_waddr = waddr_q[rd_ptr_q];
  assign out_meta     = meta_q[rd_ptr_q];
  assign byp_valid    = busy_q[rd_ptr_q] & rf_we_q[rd_ptr_q];
  assign byp_waddr    = waddr_q[rd_ptr_q];
  assign byp_data_rdy = out_valid;
  assign byp_data     = out_result;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i]    <= 1'b0;
        is_load_q[i] <= 1'b0;
        got_q[i]     <= 1'b0;
        ld_ctrl_q[i] <= '0;
        addr_lo_q[i] <= '0;
        word_q[i]    <= '0;
        rf_we_q[i]   <= 1'b0;
        waddr_q[i]   <= '0;
        meta_q[i]    <= '0;
      end
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= discard_flush;
      for (int i = 0; i < DEPTH; i++) busy_q[i] <= 1'b0;
    end else begin
      if (push) begin
        busy_q[wr_ptr_q]    <= 1'b1;
        is_load_q[wr_ptr_q] <= in_is_load;
        got_q[wr_ptr_q]     <= ~in_is_load;
        ld_ctrl_q[wr_ptr_q] <= in_ld_ctrl;
        addr_lo_q[wr_ptr_q] <= in_addr_lo;
        word_q[wr_ptr_q]    <= in_result;
        rf_we_q[wr_ptr_q]   <= in_rf_we;
        waddr_q[wr_ptr_q]   <= in_rf_waddr;
        meta_q[wr_ptr_q]    <= in_meta;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (data_ok) begin
        if (discard_q != '0) begin
          discard_q <= discard_q - CW'(1);
        end else if (has_wait) begin
          word_q[resp_ptr] <= rdata;
          got_q[resp_ptr]  <= 1'b1;
        end
      end
      // A cut-through pop retires the entry here, so the store above is harmless.
      if (pop) begin
        busy_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue (DEPTH=2): load extraction table plus ordering/flush/latency sequences.
module tb_mem_resp_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, in_is_load, in_rf_we;
  logic [4:0]  in_ld_ctrl, in_rf_waddr;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_result, rdata;
  logic [63:0] in_meta, out_meta;
  logic        data_ok, flush, out_valid, out_ready, out_rf_we;
  logic [31:0] out_result, byp_data;
  logic [4:0]  out_rf_waddr, byp_waddr;
  logic        byp_valid, byp_data_rdy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_resp_queue #(.DEPTH(2), .META_W(64)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_ld_ctrl(in_ld_ctrl),
    .in_addr_lo(in_addr_lo), .in_result(in_result), .in_rf_we(in_rf_we),
    .in_rf_waddr(in_rf_waddr), .in_meta(in_meta),
    .data_ok(data_ok), .rdata(rdata), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_meta(out_meta),
    .byp_valid(byp_valid), .byp_waddr(byp_waddr), .byp_data_rdy(byp_data_rdy),
    .byp_data(byp_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic ld, input logic [4:0] ctrl, input logic [1:0] lo,
                         input logic [31:0] res, input logic [4:0] wa);
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_ld_ctrl  = ctrl;
    in_addr_lo  = lo;
    in_result   = res;
    in_rf_we    = 1'b1;
    in_rf_waddr = wa;
    in_meta     = {32'hCAFE_0000, 27'd0, wa};
  endtask

  typedef struct {
    logic [4:0]  ctrl;
    logic [1:0]  lo;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // {ld_w, ld_b, ld_bu, ld_h, ld_hu}
    vecs[0] = '{5'b01000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80};
    vecs[1] = '{5'b00100, 2'd3, 32'h80FF_0000, 32'h0000_0080};
    vecs[2] = '{5'b00001, 2'd2, 32'h80FF_0000, 32'h0000_80FF};
    vecs[3] = '{5'b00010, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF};
    vecs[4] = '{5'b10000, 2'd0, 32'h1234_5678, 32'h1234_5678};
    vecs[5] = '{5'b01000, 2'd1, 32'h0000_7F00, 32'h0000_007F};
    vecs[6] = '{5'b00010, 2'd0, 32'h1234_8001, 32'hFFFF_8001};
    vecs[7] = '{5'b00100, 2'd0, 32'hABCD_EFFE, 32'h0000_00FE};
    vecs[8] = '{5'b01000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80};

    resetn = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_ld_ctrl = '0; in_addr_lo = '0;
    in_result = '0; in_rf_we = 1'b0; in_rf_waddr = '0; in_meta = '0; data_ok = 1'b0;
    rdata = '0; flush = 1'b0; out_ready = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset byp_valid", byp_valid, 0);
    chk("reset out_result", out_result, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);

    // Load extraction table
    for (int i = 0; i < 9; i++) begin
      push_op(1'b1, vecs[i].ctrl, vecs[i].lo, 32'hFFFF_FFFF, 5'(i + 1));
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d pending out_valid", i), out_valid, 0);
      chk($sformatf("v%0d byp_valid", i), byp_valid, 1);
      chk($sformatf("v%0d byp_waddr", i), byp_waddr, i + 1);
      data_ok = 1'b1;
      rdata   = vecs[i].rd;
      @(negedge clk);
      data_ok = 1'b0;
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d out_result", i), out_result, vecs[i].exp);
      chk($sformatf("v%0d byp_data", i), byp_data, vecs[i].exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d popped", i), out_valid, 0);
    end

    // Two outstanding loads, full, in-order results
    push_op(1'b1, 5'b10000, 2'd0, 32'h0, 5'd1);
    @(negedge clk);
    push_op(1'b1, 5'b10000, 2'd0, 32'h0, 5'd2);
    @(negedge clk);
    chk("full in_ready", in_ready, 0);
    push_op(1'b0, 5'b0, 2'd0, 32'h99, 5'd9);
    data_ok = 1'b1;
    rdata   = 32'h11;
    @(negedge clk);
    in_valid = 1'b0;
    rdata    = 32'h22;
    chk("ord first ready", out_valid, 1);
    @(negedge clk);
    data_ok = 1'b0;
    chk("ord first result", out_result, 32'h11);
    chk("ord first waddr", out_rf_waddr, 1);
    chk("ord first meta", out_meta, {32'hCAFE_0000, 32'd1});
    out_ready = 1'b1;
    @(negedge clk);
    chk("ord second result", out_result, 32'h22);
    chk("ord second waddr", out_rf_waddr, 2);
    @(negedge clk);
    out_ready = 1'b0;
    chk("ord drained out_valid", out_valid, 0);
    chk("ord drained in_ready", in_ready, 1);

    // Flush with outstanding load, late response discarded
    push_op(1'b1, 5'b10000, 2'd0, 32'h0, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    push_op(1'b0, 5'b0, 2'd0, 32'h5, 5'd7);
    @(negedge clk);
    in_valid = 1'b0;
    chk("discard alu out_valid", out_valid, 1);
    chk("discard alu result", out_result, 32'h5);
    chk("discard blocks in_ready", in_ready, 0);
    data_ok = 1'b1;
    rdata   = 32'hDEAD;
    @(negedge clk);
    data_ok = 1'b0;
    chk("dropped keeps result", out_result, 32'h5);
    chk("dropped frees slot", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("discard drained", out_valid, 0);

    // Flush coincident with data_ok: nothing left to discard
    push_op(1'b1, 5'b10000, 2'd0, 32'h0, 5'd4);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    data_ok  = 1'b1;
    rdata    = 32'h77;
    @(negedge clk);
    flush   = 1'b0;
    data_ok = 1'b0;
    chk("flush+ok out_valid", out_valid, 0);
    chk("flush+ok byp_valid", byp_valid, 0);
    chk("flush+ok in_ready", in_ready, 1);
    push_op(1'b1, 5'b10000, 2'd0, 32'h0, 5'd5);
    @(negedge clk);
    in_valid = 1'b0;
    data_ok  = 1'b1;
    rdata    = 32'h42;
    @(negedge clk);
    data_ok = 1'b0;
    chk("no stale discard valid", out_valid, 1);
    chk("no stale discard result", out_result, 32'h42);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // data_ok -> out_valid latency
    push_op(1'b1, 5'b10000, 2'd0, 32'h0, 5'd6);
    @(negedge clk);
    in_valid  = 1'b0;
    data_ok   = 1'b1;
    rdata     = 32'h1234;
    out_ready = 1'b1;
    #1;
`ifdef MEM_RESP_CUT_THROUGH_EN
    chk("cut same-cycle valid", out_valid, 1);
    chk("cut same-cycle result", out_result, 32'h1234);
    @(negedge clk);
    data_ok = 1'b0;
    chk("cut retired", out_valid, 0);
`else
    chk("no cut same-cycle valid", out_valid, 0);
    @(negedge clk);
    data_ok = 1'b0;
    chk("next-cycle valid", out_valid, 1);
    chk("next-cycle result", out_result, 32'h1234);
    @(negedge clk);
    chk("next-cycle retired", out_valid, 0);
`endif
    out_ready = 1'b0;
    @(negedge clk);
    chk("final in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
